dm_port_arbiter: RTL
====================

Name: dm_port_arbiter

Overview:
- Shares the single data-memory port (`m_data_*` bus: word-addressed memory, combinational read, byte-enabled write on posedge) between two requesters.
- Requester 0 is the CPU MEM stage. Requester 1 is a secondary master (DMA/debug loader).
- Fixed priority to port 0, with a starvation limiter and a locked-burst mode for port 1.
- Sits between the pipeline's MEM stage and the data memory.

Parameters:
- STARVE_LIM, 4, consecutive denied cycles of a pending r1_req after which port 1 is forced to win (legal range 1..15).
- LOCK_MAX, 8, maximum consecutive locked grants to port 1 before returning to port-0 priority (legal range 1..255).

Ports:
- clk  in  1  clock; all state on posedge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- r0_req  in  1  port 0 access request.
- r0_addr  in  32  port 0 byte address.
- r0_wdata  in  32  port 0 write data.
- r0_byteen  in  4  port 0 byte enables; 4'b0000 = read.
- r0_gnt  out  1  port 0 granted this cycle (combinational).
- r0_rdata  out  32  port 0 registered read data.
- r0_rvalid  out  1  one-cycle pulse: r0_rdata valid.
- r1_req, r1_addr, r1_wdata, r1_byteen, r1_gnt, r1_rdata, r1_rvalid: same as port 0, for port 1.
- r1_lock  in  1  request that port 1 keep priority on the next cycle (burst).
- m_data_addr  out  32  memory address, from the granted port.
- m_data_wdata  out  32  memory write data, from the granted port.
- m_data_byteen  out  4  memory byte enables; nonzero only in a granted write cycle.
- m_data_rdata  in  32  memory combinational read data.
- stat_gnt0  out  32  port 0 grant count (optional feature).
- stat_gnt1  out  32  port 1 grant count (optional feature).

Behaviour:
- State machine: two states, PRI0 (default) and LOCK1. Internal counters: starve_cnt (4b) and beat_cnt (8b).
- Grant in PRI0:
  - port 1 wins if r1_req && (!r0_req || starve_cnt == STARVE_LIM);
  - otherwise port 0 wins if r0_req.
- Grant in LOCK1: port 1 wins if r1_req; otherwise port 0 wins if r0_req.
- At most one of r0_gnt/r1_gnt is high. Both are 0 while reset is low.
- Memory mux:
  - m_data_addr/m_data_wdata follow the granted port (port 0 when idle).
  - m_data_byteen = granted port's byteen, else 4'b0000.
  - Address is passed unmodified; the memory handles alignment.
- Read latency 1:
  - a granted read (byteen == 0) latches m_data_rdata into rN_rdata at that posedge;
  - rN_rvalid is high for exactly the following cycle.
  - Writes never raise rvalid.
  - rN_rdata holds its value until the next read of that port.
- starve_cnt:
  - +1 each cycle r1_req && !r1_gnt, saturating at STARVE_LIM;
  - cleared on r1_gnt or when r1_req is low.
- PRI0 -> LOCK1: on a port-1 grant with r1_lock = 1. beat_cnt is set to 1.
- LOCK1 -> PRI0 on any of: a port-1 grant with r1_lock = 0; r1_req low; beat_cnt == LOCK_MAX at a port-1 grant.
- In LOCK1, beat_cnt increments on each port-1 grant.
- Requester contract: a denied requester holds req/addr/wdata/byteen stable until granted. The arbiter does not queue requests.
- Reset (asynchronous, any cycle including mid-burst):
  - state = PRI0; starve_cnt = 0; beat_cnt = 0;
  - r0_rdata = r1_rdata = 0; r0_rvalid = r1_rvalid = 0; stat counters = 0;
  - gnt and m_data_byteen are forced 0 combinationally.
  - A pending rvalid is dropped.

Optional Feature:
- Macro: DM_ARB_STATS_EN.
- When defined: stat_gnt0/stat_gnt1 increment by 1 on each posedge with the respective grant, wrap at 2^32, and are cleared by reset.
- When undefined: both outputs are tied to 32'h0 and no counter registers exist. The port list is unchanged.

Test Plan:
1. Only r0_req, read of addr 0x10, memory word 0x12345678 -> r0_gnt = 1 in the same cycle; next cycle r0_rvalid = 1 and r0_rdata = 0x12345678; r1 outputs idle.
2. Both ports request continuously, STARVE_LIM = 4, r1_lock = 0 -> port 0 granted for 4 cycles, port 1 on the 5th; pattern repeats 4:1; starve_cnt resets to 0 after each port-1 grant.
3. r1 write burst with r1_lock = 1, r0_req held high, LOCK_MAX = 8 -> after the first port-1 grant, port 1 is granted 8 consecutive cycles in total; port 0 is granted on the 9th cycle.
4. Port-0 write, byteen = 4'b0011, wdata 0xAABBCCDD to 0x20 -> m_data_byteen = 4'b0011 for exactly one cycle; no rvalid pulse; subsequent read of 0x20 returns 0x0000CCDD (memory initially 0).
5. Assert reset low mid-burst, one cycle after a granted port-1 read -> r1_rvalid is never raised; gnt = 0 while reset is low; after release, r0_req wins immediately (state PRI0).
6. With DM_ARB_STATS_EN defined, run scenario 2 for 20 cycles -> stat_gnt0 = 16 and stat_gnt1 = 4. Without the macro, both read 0.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter for the single data-memory port: fixed priority to the CPU (port 0),
// starvation limiter and locked bursts for port 1. Define DM_ARB_STATS_EN to build grant counters.
module dm_port_arbiter #(
    parameter int unsigned STARVE_LIM = 4,
    parameter int unsigned LOCK_MAX   = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        r0_req,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    input  logic [3:0]  r0_byteen,
    output logic        r0_gnt,
    output logic [31:0] r0_rdata,
    output logic        r0_rvalid,

    input  logic        r1_req,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    input  logic [3:0]  r1_byteen,
    input  logic        r1_lock,
    output logic        r1_gnt,
    output logic [31:0] r1_rdata,
    output logic        r1_rvalid,

    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_rdata,

    output logic [31:0] stat_gnt0,
    output logic [31:0] stat_gnt1
);

    typedef enum logic {
        PRI0  = 1'b0,
        LOCK1 = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIM);
    localparam logic [7:0] LOCK_MAX_C   = 8'(LOCK_MAX);

    state_t     state, state_next;
    logic [3:0] starve_cnt, starve_next;
    logic [7:0] beat_cnt, beat_next;
    logic       gnt0, gnt1;

    // Grants are gated by reset so nothing reaches the memory while reset is held.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            if (state == LOCK1) begin
                gnt1 = r1_req;
            end else begin
                gnt1 = r1_req && (!r0_req || starve_cnt == STARVE_LIM_C);
            end
            gnt0 = r0_req && !gnt1;
        end
    end

    assign r0_gnt = gnt0;
    assign r1_gnt = gnt1;

    always_comb begin
        m_data_addr   = gnt1 ? r1_addr  : r0_addr;
        m_data_wdata  = gnt1 ? r1_wdata : r0_wdata;
        m_data_byteen = 4'b0000;
        if (gnt1) begin
            m_data_byteen = r1_byteen;
        end else if (gnt0) begin
            m_data_byteen = r0_byteen;
        end
    end

    // beat_cnt counts port-1 grants of the current burst, including the one that opened it.
    always_comb begin
        state_next = state;
        beat_next  = beat_cnt;
        unique case (state)
            PRI0: begin
                if (gnt1 && r1_lock && LOCK_MAX_C > 8'd1) begin
                    state_next = LOCK1;
                    beat_next  = 8'd1;
                end
            end
            LOCK1: begin
                if (!r1_req) begin
                    state_next = PRI0;
                end else if (gnt1) begin
                    beat_next = beat_cnt + 8'd1;
                    if (!r1_lock || beat_next >= LOCK_MAX_C) begin
                        state_next = PRI0;
                    end
                end
            end
            default: state_next = PRI0;
        endcase
    end

    always_comb begin
        starve_next = 4'd0;
        if (r1_req && !gnt1) begin
            starve_next = (starve_cnt >= STARVE_LIM_C) ? STARVE_LIM_C : starve_cnt + 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= PRI0;
            starve_cnt <= 4'd0;
            beat_cnt   <= 8'd0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            beat_cnt   <= beat_next;
        end
    end

    // Read data is registered once per granted read and held until that port's next read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r0_rdata  <= 32'h0;
            r1_rdata  <= 32'h0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
        end else begin
            r0_rvalid <= gnt0 && (r0_byteen == 4'b0000);
            r1_rvalid <= gnt1 && (r1_byteen == 4'b0000);
            if (gnt0 && r0_byteen == 4'b0000) begin
                r0_rdata <= m_data_rdata;
            end
            if (gnt1 && r1_byteen == 4'b0000) begin
                r1_rdata <= m_data_rdata;
            end
        end
    end

`ifdef DM_ARB_STATS_EN
    logic [31:0] stat0_q, stat1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat0_q <= 32'h0;
            stat1_q <= 32'h0;
        end else begin
            if (gnt0) stat0_q <= stat0_q + 32'd1;
            if (gnt1) stat1_q <= stat1_q + 32'd1;
        end
    end

    assign stat_gnt0 = stat0_q;
    assign stat_gnt1 = stat1_q;
`else
    assign stat_gnt0 = 32'h0;
    assign stat_gnt1 = 32'h0;
`endif

endmodule
